// File: rtl/uart_transmitter_fifo.sv
// 8N1 UART transmitter fed by a FIFO.
// Baud timing comes from a fractional phase accumulator shared with the receiver.
module uart_transmitter_fifo #(
  parameter int bitDepth = 11,
  parameter int adder = 151,
  parameter int addrWidth = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_8_data,
  input  logic                 i_write,
  output logic                 o_full,
  output logic [addrWidth:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_tx
);

  localparam int Depth = 1 << addrWidth;
  localparam logic [addrWidth:0] DepthW = (addrWidth+1)'(Depth);
  localparam logic [bitDepth-1:0] Step = bitDepth'(adder);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [7:0]           mem [Depth];
  logic [addrWidth-1:0] wr_ptr;
  logic [addrWidth-1:0] rd_ptr;
  logic [bitDepth-1:0]  acc;
  logic [bitDepth:0]    sum;
  logic [7:0]           shift;
  logic [7:0]           head;
  logic [2:0]           idx;
  logic [addrWidth:0]   count_nxt;
  logic                 tick;
  logic                 wr;
  logic                 pop;
  logic                 have;
  logic                 go_idle;
  logic                 at_end;

  assign sum = {1'b0, acc} + {1'b0, Step};
  assign tick = sum[bitDepth];
  assign have = o_count != '0;
  assign wr = i_write & ~o_full;
  assign at_end = (state == IDLE) | ((state == STOP) & tick);
  assign pop = have & at_end;
  assign go_idle = ~have & at_end;
  assign head = mem[rd_ptr];
  assign count_nxt = o_count + (addrWidth+1)'(wr)
                   - (addrWidth+1)'(pop);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= i_8_data;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_full     <= 1'b0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + addrWidth'(1);
      if (pop) rd_ptr <= rd_ptr + addrWidth'(1);
      o_count <= count_nxt;
      o_full  <= count_nxt == DepthW;
      if (i_write & o_full) o_overflow <= 1'b1;
      o_busy <= ~go_idle | (count_nxt != '0);
    end
  end

  // acc is zeroed on every pop so each frame's start bit is full length
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      acc   <= '0;
      shift <= '0;
      idx   <= '0;
      o_tx  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (have) begin
            shift <= head;
            acc   <= '0;
            state <= START;
            o_tx  <= 1'b0;
          end
        end
        START: begin
          acc <= sum[bitDepth-1:0];
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            o_tx  <= shift[0];
          end
        end
        DATA: begin
          acc <= sum[bitDepth-1:0];
          if (tick) begin
            shift <= {1'b0, shift[7:1]};
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              o_tx <= shift[1];
            end
          end
        end
        STOP: begin
          acc <= sum[bitDepth-1:0];
          if (tick) begin
            if (have) begin
              shift <= head;
              acc   <= '0;
              state <= START;
              o_tx  <= 1'b0;
            end else begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter_fifo.md
Name: uart_transmitter_fifo

Overview:
- 8N1 UART transmitter with an input FIFO; PC-facing transmit end, complementing the existing uart_receiver.
- Accepts bytes from upstream logic (interfpga receive path, CRC/status reporters) with a write/full handshake.
- Serialises queued bytes back-to-back on o_tx.
- Baud timing uses the same fractional accumulator scheme as uart_receiver (bitDepth/adder), so both ends of the link share one rate setup.

Parameters:
- bitDepth, 11, width of the baud phase accumulator.
- adder, 151, accumulator increment per clock. Bit rate = f_clk*adder/2^bitDepth. Must satisfy 0 < adder < 2^bitDepth.
- addrWidth, 4, FIFO address width. Depth = 2^addrWidth entries.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  asynchronous reset, active-low (0 = reset).
- i_8_data  in  8  byte to enqueue.
- i_write  in  1  enqueue strobe; samples i_8_data on a rising edge when high.
- o_full  out  1  FIFO holds 2^addrWidth entries.
- o_count  out  addrWidth+1  current FIFO occupancy.
- o_overflow  out  1  sticky flag: a write was attempted while o_full was high.
- o_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- o_tx  out  1  serial line; idle high.

Behaviour:
- Reset (i_reset low, asynchronous):
  - o_tx=1, o_full=0, o_count=0, o_overflow=0, o_busy=0.
  - FIFO pointers, baud accumulator and shift register are cleared; state goes to IDLE.
  - Reset mid-frame aborts the frame immediately (o_tx goes high without waiting for a clock edge). Queued data is discarded.
- FIFO writes:
  - A write is accepted iff i_write=1 and the registered o_full=0.
  - A write while o_full=1 is dropped and sets o_overflow. This holds even if a pop occurs in the same cycle; the full check uses the pre-edge value.
  - A simultaneous accepted write and pop leaves o_count unchanged.
  - o_full and o_count are registered and update on the edge after the event.
  - Pointers wrap modulo 2^addrWidth.
- Baud tick:
  - acc <= acc + adder (bitDepth bits) on every clock while state != IDLE.
  - tick = carry out of that add.
  - acc is cleared to 0 on every entry to START, so the first bit of each frame is never short.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If o_count != 0: pop the head into the shift register, clear acc, go to START.
  - START: o_tx=0. On tick, go to DATA with bit index 0.
  - DATA: o_tx = shift[0], LSB first. On tick, shift right and increment the index. After the tick of bit 7, go to STOP.
  - STOP: o_tx=1. On tick: if the FIFO is non-empty, pop and go to START (no idle gap between frames); otherwise go to IDLE.
- Timing:
  - A write sampled at edge k into an empty FIFO in IDLE is counted at edge k.
  - The FSM pops at edge k+1; o_tx falls after edge k+1.
  - Each bit lasts one tick interval (2^bitDepth/adder clocks on average, ±1 clock when not integral). A frame is 10 intervals.
- o_busy = (state != IDLE) | (o_count != 0), registered.
- i_write and i_8_data are assumed synchronous to i_clk. No internal synchroniser.

Test Plan:
Bench parameters: bitDepth=4, adder=4, addrWidth=2 (tick every 4 clocks, depth 4), unless noted.
1. Single byte: write 0xA5 when idle → o_tx low after the next edge. Line sequence at 4 clocks/bit: 0, 1,0,1,0,0,1,0,1, 1. o_busy drops 40 clocks after the start edge; o_count returns to 0.
2. Burst: writes of 0x01..0x05 on 5 consecutive edges → all accepted (first is popped at edge 1); o_full=1 after edge 4, o_overflow=0. Five frames go out contiguously with no high gap beyond stop bits (200 clocks total). The decoded bytes match in order.
3. Overflow: with the FIFO full and a STOP tick popping on the same edge, assert i_write with 0x77 → byte dropped, o_overflow=1, o_count=3 after the edge. 0x77 never appears on o_tx. The flag stays set until reset.
4. Reset mid-frame: assert i_reset=0 during DATA bit 3 with 2 bytes queued → o_tx=1 asynchronously; o_count=0, o_busy=0, o_overflow=0. After release, no further edges appear on o_tx.
5. Fractional baud: bitDepth=4, adder=5, send 0x00 → each bit is 3 or 4 clocks. The start-to-stop-end frame length is 32±1 clocks, and the first START bit is exactly 4 clocks (acc cleared).
6. Wrap-around: stream 12 bytes (0x10..0x1B) while keeping the FIFO non-full → pointers wrap 3 times and all 12 bytes are received in order.
